// File: rtl/axi_b_inject_arb.sv
// Merges downstream B responses with locally injected SLVERR responses onto one
// upstream B channel; injects are queued in a small FIFO, arbitration is round-robin.
module axi_b_inject_arb #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned UserWidth = 2,
  parameter int unsigned InjDepth  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           inj_valid_i,
  input  logic [IdWidth-1:0]             inj_id_i,
  output logic                           inj_ready_o,
  input  logic                           mst_b_valid_i,
  input  logic [IdWidth-1:0]             mst_b_id_i,
  input  logic [1:0]                     mst_b_resp_i,
  input  logic [UserWidth-1:0]           mst_b_user_i,
  output logic                           mst_b_ready_o,
  output logic                           slv_b_valid_o,
  output logic [IdWidth-1:0]             slv_b_id_o,
  output logic [1:0]                     slv_b_resp_o,
  output logic [UserWidth-1:0]           slv_b_user_o,
  input  logic                           slv_b_ready_i,
  output logic [$clog2(InjDepth+1)-1:0]  inj_cnt_o
);

  localparam int unsigned CntW = $clog2(InjDepth + 1);
  localparam int unsigned PtrW = (InjDepth > 1) ? $clog2(InjDepth) : 1;

  typedef enum logic {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic              grant_inj_q, grant_inj_d;
  logic              prio_inj_q, prio_inj_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdWidth-1:0] fifo_q [InjDepth];

  logic inj_avail, grant_inj, sel_mst_rdy, handshake, push, pop;

  assign inj_avail   = (cnt_q != '0);
  assign inj_ready_o = (cnt_q < CntW'(InjDepth));
  assign inj_cnt_o   = cnt_q;
  assign push        = inj_valid_i && inj_ready_o;

  always_comb begin
    state_d     = state_q;
    grant_inj_d = grant_inj_q;
    prio_inj_d  = prio_inj_q;
    grant_inj   = 1'b0;
    sel_mst_rdy = 1'b0;
    if (state_q == StIdle) begin
      grant_inj   = inj_avail && (!mst_b_valid_i || prio_inj_q);
      // Ready assumes downstream would win if it were valid, so it never depends on mst_b_valid_i.
      sel_mst_rdy = !(inj_avail && prio_inj_q);
    end else begin
      grant_inj   = grant_inj_q;
      sel_mst_rdy = !grant_inj_q;
    end

    slv_b_valid_o = rst_ni && (grant_inj ? inj_avail : mst_b_valid_i);
    mst_b_ready_o = rst_ni && slv_b_ready_i && sel_mst_rdy;
    handshake     = slv_b_valid_o && slv_b_ready_i;
    pop           = handshake && grant_inj;

    if (grant_inj) begin
      slv_b_id_o   = fifo_q[rd_ptr_q];
      slv_b_resp_o = 2'b10;
      slv_b_user_o = '0;
    end else begin
      slv_b_id_o   = mst_b_id_i;
      slv_b_resp_o = mst_b_resp_i;
      slv_b_user_o = mst_b_user_i;
    end

    if (state_q == StIdle) begin
      if (slv_b_valid_o && !slv_b_ready_i) begin
        state_d     = StLocked;
        grant_inj_d = grant_inj;
      end
    end else if (handshake) begin
      state_d = StIdle;
    end
    if (handshake) prio_inj_d = !grant_inj;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(InjDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(InjDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      grant_inj_q <= 1'b0;
      prio_inj_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_inj_q <= grant_inj_d;
      prio_inj_q  <= prio_inj_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= inj_id_i;
  end

endmodule

// File: tb/tb_axi_b_inject_arb.sv
// Directed and randomised checks of the B-channel inject arbiter with default parameters.
module tb_axi_b_inject_arb;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       inj_valid_i;
  logic [3:0] inj_id_i;
  logic       inj_ready_o;
  logic       mst_b_valid_i;
  logic [3:0] mst_b_id_i;
  logic [1:0] mst_b_resp_i;
  logic [1:0] mst_b_user_i;
  logic       mst_b_ready_o;
  logic       slv_b_valid_o;
  logic [3:0] slv_b_id_o;
  logic [1:0] slv_b_resp_o;
  logic [1:0] slv_b_user_o;
  logic       slv_b_ready_i;
  logic [2:0] inj_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [3:0] inj_q [$];
  logic       prev_stall = 1'b0;
  logic [3:0] prev_id;
  logic [1:0] prev_resp, prev_user;

  axi_b_inject_arb #(.IdWidth(4), .UserWidth(2), .InjDepth(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inj_valid_i(inj_valid_i), .inj_id_i(inj_id_i), .inj_ready_o(inj_ready_o),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_id_i(mst_b_id_i), .mst_b_resp_i(mst_b_resp_i),
    .mst_b_user_i(mst_b_user_i), .mst_b_ready_o(mst_b_ready_o),
    .slv_b_valid_o(slv_b_valid_o), .slv_b_id_o(slv_b_id_o), .slv_b_resp_o(slv_b_resp_o),
    .slv_b_user_o(slv_b_user_o), .slv_b_ready_i(slv_b_ready_i), .inj_cnt_o(inj_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_cycle(input bit drain);
    logic mst_hs;
    if (!drain) begin
      if (!mst_b_valid_i && $urandom_range(0, 2) == 0) begin
        mst_b_valid_i = 1'b1;
        mst_b_id_i    = 4'($urandom_range(0, 15));
        mst_b_resp_i  = 2'($urandom_range(0, 3));
        mst_b_user_i  = 2'($urandom_range(0, 3));
      end
      inj_valid_i   = ($urandom_range(0, 2) == 0);
      inj_id_i      = 4'($urandom_range(0, 15));
      slv_b_ready_i = ($urandom_range(0, 1) == 1);
    end else begin
      inj_valid_i   = 1'b0;
      slv_b_ready_i = 1'b1;
    end
    #2;
    if (prev_stall) begin
      check_eq("rnd_stable_valid", slv_b_valid_o, 1);
      check_eq("rnd_stable_id", slv_b_id_o, prev_id);
      check_eq("rnd_stable_resp", slv_b_resp_o, prev_resp);
      check_eq("rnd_stable_user", slv_b_user_o, prev_user);
    end
    mst_hs = mst_b_valid_i && mst_b_ready_o;
    if (slv_b_valid_o && slv_b_ready_i) begin
      if (mst_hs) begin
        check_eq("rnd_mst_id", slv_b_id_o, mst_b_id_i);
        check_eq("rnd_mst_resp", slv_b_resp_o, mst_b_resp_i);
        check_eq("rnd_mst_user", slv_b_user_o, mst_b_user_i);
      end else begin
        check_eq("rnd_inj_pending", inj_q.size() > 0, 1);
        if (inj_q.size() > 0) begin
          check_eq("rnd_inj_id", slv_b_id_o, inj_q[0]);
          check_eq("rnd_inj_resp", slv_b_resp_o, 2'b10);
          check_eq("rnd_inj_user", slv_b_user_o, 2'b00);
          void'(inj_q.pop_front());
        end
      end
    end else begin
      check_eq("rnd_no_lost_mst", mst_hs, 0);
    end
    if (inj_valid_i && inj_ready_o) inj_q.push_back(inj_id_i);
    prev_stall = slv_b_valid_o && !slv_b_ready_i;
    prev_id    = slv_b_id_o;
    prev_resp  = slv_b_resp_o;
    prev_user  = slv_b_user_o;
    tick();
    if (mst_hs) mst_b_valid_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; inj_valid_i = 1'b0; inj_id_i = '0;
    mst_b_valid_i = 1'b1; mst_b_id_i = 4'd9; mst_b_resp_i = 2'b00; mst_b_user_i = 2'b01;
    slv_b_ready_i = 1'b1;
    #12;
    check_eq("rst_inj_ready", inj_ready_o, 1);
    check_eq("rst_slv_valid", slv_b_valid_o, 0);
    check_eq("rst_mst_ready", mst_b_ready_o, 0);
    check_eq("rst_cnt", inj_cnt_o, 0);
    mst_b_valid_i = 1'b0;
    rst_ni = 1'b1;
    tick();

    // downstream pass-through
    mst_b_valid_i = 1'b1; mst_b_id_i = 4'd3; mst_b_resp_i = 2'b00; mst_b_user_i = 2'b01;
    #1;
    check_eq("pt_valid", slv_b_valid_o, 1);
    check_eq("pt_id", slv_b_id_o, 3);
    check_eq("pt_resp", slv_b_resp_o, 2'b00);
    check_eq("pt_user", slv_b_user_o, 2'b01);
    check_eq("pt_mst_ready", mst_b_ready_o, 1);
    tick();
    mst_b_valid_i = 1'b0;

    // fill the inject FIFO while stalled, then drain in order
    slv_b_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      inj_valid_i = 1'b1; inj_id_i = 4'(i);
      #1;
      check_eq("fill_inj_ready", inj_ready_o, 1);
      tick();
    end
    check_eq("fill_cnt", inj_cnt_o, 4);
    check_eq("fill_full_ready", inj_ready_o, 0);
    inj_id_i = 4'd9;
    tick();
    check_eq("fill_fifth_refused", inj_cnt_o, 4);
    inj_valid_i = 1'b0;
    slv_b_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq("drain_valid", slv_b_valid_o, 1);
      check_eq("drain_id", slv_b_id_o, i);
      check_eq("drain_resp", slv_b_resp_o, 2'b10);
      tick();
    end
    check_eq("drain_cnt", inj_cnt_o, 0);
    check_eq("drain_idle_valid", slv_b_valid_o, 0);

    // round robin: both sources valid
    slv_b_ready_i = 1'b0;
    mst_b_valid_i = 1'b1; mst_b_id_i = 4'd5; mst_b_resp_i = 2'b01; mst_b_user_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      inj_valid_i = 1'b1; inj_id_i = 4'd7;
      #1;
      check_eq("rr_stall_mst_ready", mst_b_ready_o, 0);
      tick();
    end
    inj_valid_i = 1'b0;
    slv_b_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("rr_id", slv_b_id_o, (i % 2 == 0) ? 5 : 7);
      check_eq("rr_mst_ready", mst_b_ready_o, (i % 2 == 0) ? 1 : 0);
      tick();
    end
    check_eq("rr_cnt", inj_cnt_o, 2);
    mst_b_valid_i = 1'b0;
    tick(); tick();
    check_eq("rr_drained", inj_cnt_o, 0);

    // locked inject grant holds off a later downstream response
    slv_b_ready_i = 1'b0;
    inj_valid_i = 1'b1; inj_id_i = 4'd2;
    tick();
    inj_valid_i = 1'b0;
    #1;
    check_eq("lock_c1_id", slv_b_id_o, 2);
    check_eq("lock_c1_resp", slv_b_resp_o, 2'b10);
    tick();
    mst_b_valid_i = 1'b1; mst_b_id_i = 4'd6; mst_b_resp_i = 2'b00; mst_b_user_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("lock_hold_id", slv_b_id_o, 2);
      check_eq("lock_hold_resp", slv_b_resp_o, 2'b10);
      check_eq("lock_hold_mst_ready", mst_b_ready_o, 0);
      tick();
    end
    slv_b_ready_i = 1'b1;
    #1;
    check_eq("lock_hs_id", slv_b_id_o, 2);
    check_eq("lock_hs_mst_ready", mst_b_ready_o, 0);
    tick();
    #1;
    check_eq("lock_next_id", slv_b_id_o, 6);
    check_eq("lock_next_resp", slv_b_resp_o, 2'b00);
    check_eq("lock_next_mst_ready", mst_b_ready_o, 1);
    tick();
    mst_b_valid_i = 1'b0;

    // full FIFO: push refused while popping, accepted next cycle
    slv_b_ready_i = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      inj_valid_i = 1'b1; inj_id_i = 4'(i);
      tick();
    end
    check_eq("full_cnt", inj_cnt_o, 4);
    slv_b_ready_i = 1'b1; inj_id_i = 4'd15;
    #1;
    check_eq("full_push_ready", inj_ready_o, 0);
    check_eq("full_pop_id", slv_b_id_o, 10);
    tick();
    check_eq("full_after_pop_cnt", inj_cnt_o, 3);
    slv_b_ready_i = 1'b0; inj_id_i = 4'd14;
    #1;
    check_eq("full_repush_ready", inj_ready_o, 1);
    tick();
    check_eq("full_repush_cnt", inj_cnt_o, 4);
    inj_valid_i = 1'b0;
    slv_b_ready_i = 1'b1;
    for (int i = 11; i <= 14; i++) begin
      #1;
      check_eq("full_drain_id", slv_b_id_o, i);
      tick();
    end
    check_eq("full_drain_cnt", inj_cnt_o, 0);

    // asynchronous reset while locked with two buffered injects
    slv_b_ready_i = 1'b0;
    for (int i = 8; i <= 9; i++) begin
      inj_valid_i = 1'b1; inj_id_i = 4'(i);
      tick();
    end
    inj_valid_i = 1'b0;
    check_eq("arst_pre_cnt", inj_cnt_o, 2);
    check_eq("arst_pre_valid", slv_b_valid_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("arst_cnt", inj_cnt_o, 0);
    check_eq("arst_inj_ready", inj_ready_o, 1);
    check_eq("arst_slv_valid", slv_b_valid_o, 0);
    check_eq("arst_mst_ready", mst_b_ready_o, 0);
    #2;
    rst_ni = 1'b1;
    slv_b_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("arst_quiet_valid", slv_b_valid_o, 0);
      check_eq("arst_quiet_cnt", inj_cnt_o, 0);
    end
    mst_b_valid_i = 1'b1; mst_b_id_i = 4'd4; mst_b_resp_i = 2'b00; mst_b_user_i = 2'b00;
    #1;
    check_eq("arst_new_valid", slv_b_valid_o, 1);
    check_eq("arst_new_id", slv_b_id_o, 4);
    tick();
    mst_b_valid_i = 1'b0;

    // random traffic with scoreboard
    prev_stall = 1'b0;
    for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 64; c++) rand_cycle(1'b1);
    check_eq("rnd_all_inj_emitted", inj_q.size(), 0);
    check_eq("rnd_final_cnt", inj_cnt_o, 0);
    check_eq("rnd_mst_completed", mst_b_valid_i, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
